ats21: RTL and testbench
========================

# ats21

The `ATS21` block is a single-request arithmetic transaction server. A requester presents a control-word pair (`ctrlA`, `ctrlB`) with `req`. The block computes one of four operations (add, subtract, multiply, accumulate) and returns a 24-bit result on `data`, with a 2-bit completion status on `stat`. It sits behind a simple ready/request handshake and handles one transaction at a time.

## Interface
- Parameters: none.
- `clk`  input  1  rising-edge clock; the single clock domain.
- `reset`  input  1  synchronous, active-high reset, sampled on the `clk` rising edge.
- `req`  input  1  request strobe; a transaction is accepted when `req`=1 and `ready`=1 at a rising edge.
- `ctrlA`  input  16  `[15:14]` opcode, `[13:0]` operand A.
- `ctrlB`  input  16  operand B (unsigned).
- `ready`  output  1  registered; 1 means the block can accept a request.
- `stat`  output  2  registered status: 00 IDLE, 01 BUSY, 10 DONE, 11 ERROR.
- `data`  output  24  registered result of the last completed transaction.

## Operation
- **States:**
  - IDLE (after reset): `stat`=00.
  - BUSY: `stat`=01, `ready`=0.
  - DONE: `stat`=10.
  - ERROR: `stat`=11.
  - `ready`=1 in IDLE, DONE and ERROR.
- **Accept:** in IDLE/DONE/ERROR with `req`=1, capture opcode, A, B and go to BUSY.
  - `req` while BUSY is ignored; no queueing.
  - `ctrlA`/`ctrlB` are only sampled at acceptance.
- **Opcode 00, ADD:** `data` = zero-extended A + zero-extended B. Cannot overflow; always ends in DONE.
- **Opcode 01, SUB:** `data` = B − A, 24-bit two's-complement wrap.
  - Result ≥ 0: DONE.
  - Result negative (A > B): ERROR, with `data` holding the wrapped value.
- **Opcode 10, MUL:** `data` = A[7:0] × B[15:0], a 24-bit unsigned product.
  - Computed by an iterative shift-add over the 8 bits of A[7:0], one bit per cycle.
  - A[13:8] is ignored. Always ends in DONE.
- **Opcode 11, ACC:**
  - If A[0]=1, the internal 24-bit accumulator is cleared first.
  - Then acc = acc + zero-extended B, and `data` = new acc.
  - Carry out of bit 23: acc wraps and the state is ERROR; otherwise DONE.
- **Hold behaviour:** `data` holds its value until the next completion. The accumulator persists across transactions of any opcode.
- **Reset** (including mid-operation):
  - The operation is aborted.
  - `ready`=1, `stat`=00, `data`=0, accumulator=0, multiplier state cleared.
  - Reset has priority over `req`.

## Timing
- Acceptance edge E0: after E0, `ready`=0 and `stat`=01.
- ADD/SUB/ACC: one BUSY cycle. At E1, `data` is updated, `stat` becomes 10 or 11, and `ready`=1.
- MUL: eight BUSY cycles. At E8, `data` is updated, `stat`=10 and `ready`=1.
- `data`, `stat` and `ready` all change on the same edge at completion.
- Acceptance uses the registered `ready` value before the edge. `req` held high from E0 is therefore next accepted at E2 (ADD) or E9 (MUL).
  - Maximum throughput: one ADD every 2 cycles.
- If `req`=1 while `reset`=1, nothing is accepted. The first acceptance is possible at the first edge with `reset`=0.

## Test plan
- **Reset:** `reset`=1 for 4 cycles with `req`=0, then release → `ready`=1, `stat`=00, `data`=0x000000, stable for 20 cycles.
- **ADD:** `ctrlA`=0x0005, `ctrlB`=0x0003, `req` pulse → `stat`=01 for 1 cycle, then `data`=0x000008, `stat`=10, `ready`=1.
- **SUB:** `ctrlA`=0x4005, `ctrlB`=0x0003 → `data`=0xFFFFFE, `stat`=11.
- **SUB:** `ctrlA`=0x4003, `ctrlB`=0x0005 → `data`=0x000002, `stat`=10.
- **MUL:** `ctrlA`=0x80FF, `ctrlB`=0xFFFF → 8 BUSY cycles, then `data`=0xFEFF01, `stat`=10.
- **ACC:**
  - `ctrlA`=0xC001, `ctrlB`=0xFFFF → `data`=0x00FFFF.
  - Then 255 further requests with `ctrlA`=0xC000, `ctrlB`=0xFFFF → `data`=0xFFFF00, `stat`=10.
  - One more with `ctrlB`=0x0100 → `data`=0x000000, `stat`=11.
- **Reset mid-MUL:** start the MUL above, assert `reset` at the 4th BUSY cycle → next edge `ready`=1, `stat`=00, `data`=0.
- **Busy ignore:** a request with `ctrlA`=0x0001, `ctrlB`=0x0001 issued while BUSY is ignored, and `data` reflects only the MUL.

Source files
------------

// File: rtl/ats21_if.sv
// Request/response bundle between a requester and the ats21 transaction server.
`timescale 1ns/1ps
interface ats21_if;
  logic        req;
  logic [15:0] ctrlA;
  logic [15:0] ctrlB;
  logic        ready;
  logic [1:0]  stat;
  logic [23:0] data;

  modport master (output req, ctrlA, ctrlB, input ready, stat, data);
  modport slave  (input req, ctrlA, ctrlB, output ready, stat, data);
endinterface

// File: rtl/ats21.sv
// Single-request arithmetic server: add, subtract, shift-add multiply and a
// persistent 24-bit accumulator, one transaction in flight at a time.
`timescale 1ns/1ps
module ats21 (
  input  logic   clk,
  input  logic   reset,
  ats21_if.slave bus
);

  // State encoding doubles as the status code driven on stat.
  typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, DONE = 2'b10, ERROR = 2'b11} state_t;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_ACC = 2'b11} op_t;

  state_t      state, state_n;
  op_t         op, op_n;
  logic [13:0] opa, opa_n;
  logic [15:0] opb, opb_n;
  logic [23:0] acc, acc_n;
  logic [23:0] data, data_n;
  logic [23:0] prod, prod_n;
  logic [23:0] mcand, mcand_n;
  logic [7:0]  mplier, mplier_n;
  logic [2:0]  cnt, cnt_n;
  logic        ready, ready_n;

  logic [24:0] acc_sum;
  logic [23:0] diff;
  logic [23:0] prod_step;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      op     <= OP_ADD;
      opa    <= '0;
      opb    <= '0;
      acc    <= '0;
      data   <= '0;
      prod   <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      ready  <= 1'b1;
    end else begin
      state  <= state_n;
      op     <= op_n;
      opa    <= opa_n;
      opb    <= opb_n;
      acc    <= acc_n;
      data   <= data_n;
      prod   <= prod_n;
      mcand  <= mcand_n;
      mplier <= mplier_n;
      cnt    <= cnt_n;
      ready  <= ready_n;
    end
  end

  always_comb begin
    state_n  = state;
    op_n     = op;
    opa_n    = opa;
    opb_n    = opb;
    acc_n    = acc;
    data_n   = data;
    prod_n   = prod;
    mcand_n  = mcand;
    mplier_n = mplier;
    cnt_n    = cnt;

    acc_sum   = (opa[0] ? 25'd0 : {1'b0, acc}) + {9'd0, opb};
    diff      = {8'd0, opb} - {10'd0, opa};
    prod_step = prod + (mplier[0] ? mcand : 24'd0);

    case (state)
      BUSY: begin
        case (op)
          OP_ADD: begin
            data_n  = {10'd0, opa} + {8'd0, opb};
            state_n = DONE;
          end
          OP_SUB: begin
            data_n  = diff;
            state_n = ({2'b00, opa} > opb) ? ERROR : DONE;
          end
          OP_MUL: begin
            // One multiplier bit per cycle; the eighth step lands the product.
            prod_n   = prod_step;
            mcand_n  = mcand << 1;
            mplier_n = mplier >> 1;
            cnt_n    = cnt + 3'd1;
            if (cnt == 3'd7) begin
              data_n  = prod_step;
              state_n = DONE;
            end
          end
          OP_ACC: begin
            acc_n   = acc_sum[23:0];
            data_n  = acc_sum[23:0];
            state_n = acc_sum[24] ? ERROR : DONE;
          end
        endcase
      end
      default: begin
        if (bus.req) begin
          op_n     = op_t'(bus.ctrlA[15:14]);
          opa_n    = bus.ctrlA[13:0];
          opb_n    = bus.ctrlB;
          prod_n   = '0;
          mcand_n  = {8'd0, bus.ctrlB};
          mplier_n = bus.ctrlA[7:0];
          cnt_n    = '0;
          state_n  = BUSY;
        end
      end
    endcase

    ready_n = (state_n != BUSY);
  end

  assign bus.ready = ready;
  assign bus.stat  = state;
  assign bus.data  = data;

endmodule

// File: tb/tb_ats21.sv
// Randomized and directed bench for ats21 against an arithmetic reference model.
`timescale 1ns/1ps
module tb_ats21;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;
  int   model_acc = 0;

  ats21_if bus ();

  ats21 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ca;
    logic [15:0] cb;
    logic [23:0] d;
    logic [1:0]  st;
    int          lat;
  } vec_t;

  // Reference: results straight from the operation definitions.
  task automatic model(input logic [15:0] ca, input logic [15:0] cb,
                       output logic [23:0] d, output logic [1:0] st, output int lat);
    int a;
    int b;
    int s;
    a   = int'(ca[13:0]);
    b   = int'(cb);
    lat = 1;
    st  = 2'b10;
    case (ca[15:14])
      2'b00: d = 24'(a + b);
      2'b01: begin
        d = 24'(b - a);
        if (a > b) st = 2'b11;
      end
      2'b10: begin
        d   = 24'(int'(ca[7:0]) * b);
        lat = 8;
      end
      default: begin
        if (ca[0]) model_acc = 0;
        s = model_acc + b;
        if (s >= (1 << 24)) begin
          s  = s - (1 << 24);
          st = 2'b11;
        end
        model_acc = s;
        d = 24'(s);
      end
    endcase
  endtask

  // Drives a request from a negedge and returns at the negedge after acceptance.
  task automatic start_txn(input logic [15:0] ca, input logic [15:0] cb);
    bus.req   = 1'b1;
    bus.ctrlA = ca;
    bus.ctrlB = cb;
    @(posedge clk);
    @(negedge clk);
    bus.req = 1'b0;
  endtask

  task automatic test_reset;
    bus.req   = 1'b0;
    bus.ctrlA = '0;
    bus.ctrlB = '0;
    reset     = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      vectors++;
      if (bus.ready !== 1'b1 || bus.stat !== 2'b00 || bus.data !== 24'h000000) begin
        miscompares++;
        $display("[TB] FAIL reset_idle cycle %0d: ready=%b stat=%b data=%h, want ready=1 stat=00 data=000000",
                 i, bus.ready, bus.stat, bus.data);
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_directed;
    vec_t q[$];
    q.push_back('{16'h0005, 16'h0003, 24'h000008, 2'b10, 1});
    q.push_back('{16'h4005, 16'h0003, 24'hFFFFFE, 2'b11, 1});
    q.push_back('{16'h4003, 16'h0005, 24'h000002, 2'b10, 1});
    q.push_back('{16'h80FF, 16'hFFFF, 24'hFEFF01, 2'b10, 8});
    q.push_back('{16'hC001, 16'hFFFF, 24'h00FFFF, 2'b10, 1});
    for (int k = 1; k <= 255; k++)
      q.push_back('{16'hC000, 16'hFFFF, 24'((k + 1) * 32'h0000FFFF), 2'b10, 1});
    q.push_back('{16'hC000, 16'h0100, 24'h000000, 2'b11, 1});
    foreach (q[n]) begin
      start_txn(q[n].ca, q[n].cb);
      for (int c = 0; c < q[n].lat; c++) begin
        if (c > 0) begin
          @(posedge clk);
          @(negedge clk);
        end
        vectors++;
        if (bus.stat !== 2'b01 || bus.ready !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL directed_busy #%0d cycle %0d: stat=%b ready=%b, want stat=01 ready=0",
                   n, c, bus.stat, bus.ready);
        end
      end
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if (bus.data !== q[n].d || bus.stat !== q[n].st || bus.ready !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL directed_done #%0d ctrlA=%h ctrlB=%h: data=%h stat=%b ready=%b, want data=%h stat=%b ready=1",
                 n, q[n].ca, q[n].cb, bus.data, bus.stat, bus.ready, q[n].d, q[n].st);
      end
    end
    model_acc = 0;
  endtask

  task automatic test_busy_ignore;
    start_txn(16'h80FF, 16'hFFFF);
    bus.req   = 1'b1;
    bus.ctrlA = 16'h0001;
    bus.ctrlB = 16'h0001;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) begin
        @(posedge clk);
        @(negedge clk);
      end
      vectors++;
      if (bus.stat !== 2'b01 || bus.ready !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL ignore_busy cycle %0d: stat=%b ready=%b, want stat=01 ready=0",
                 c, bus.stat, bus.ready);
      end
    end
    bus.req = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if (bus.data !== 24'hFEFF01 || bus.stat !== 2'b10 || bus.ready !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL ignore_done cycle %0d: data=%h stat=%b ready=%b, want data=FEFF01 stat=10 ready=1",
                 c, bus.data, bus.stat, bus.ready);
      end
    end
  endtask

  task automatic test_mul_reset;
    start_txn(16'hC000, 16'h1234);
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (bus.data !== 24'h001234 || bus.stat !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL mulrst_acc_seed: data=%h stat=%b, want data=001234 stat=10", bus.data, bus.stat);
    end
    start_txn(16'h80FF, 16'hFFFF);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    vectors++;
    if (bus.stat !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL mulrst_busy4: stat=%b, want 01", bus.stat);
    end
    // Reset must win over a simultaneous request.
    reset     = 1'b1;
    bus.req   = 1'b1;
    bus.ctrlA = 16'h0005;
    bus.ctrlB = 16'h0003;
    @(posedge clk);
    @(negedge clk);
    reset   = 1'b0;
    bus.req = 1'b0;
    for (int c = 0; c < 10; c++) begin
      vectors++;
      if (bus.ready !== 1'b1 || bus.stat !== 2'b00 || bus.data !== 24'h000000) begin
        miscompares++;
        $display("[TB] FAIL mulrst_idle cycle %0d: ready=%b stat=%b data=%h, want ready=1 stat=00 data=000000",
                 c, bus.ready, bus.stat, bus.data);
      end
      @(posedge clk);
      @(negedge clk);
    end
    start_txn(16'hC000, 16'h0005);
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (bus.data !== 24'h000005 || bus.stat !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL mulrst_acc_cleared: data=%h stat=%b, want data=000005 stat=10", bus.data, bus.stat);
    end
    model_acc = 5;
  endtask

  task automatic test_back_to_back;
    logic [15:0] va[9];
    logic [15:0] vb[9];
    for (int i = 0; i < 9; i++) begin
      va[i] = {2'b00, 14'($urandom_range(0, 16383))};
      vb[i] = 16'($urandom_range(0, 65535));
    end
    bus.req   = 1'b1;
    bus.ctrlA = va[0];
    bus.ctrlB = vb[0];
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if (bus.stat !== 2'b01 || bus.ready !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL b2b_busy #%0d: stat=%b ready=%b, want stat=01 ready=0", i, bus.stat, bus.ready);
      end
      bus.ctrlA = va[i + 1];
      bus.ctrlB = vb[i + 1];
      if (i == 7) bus.req = 1'b0;
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if (bus.data !== 24'(int'(va[i]) + int'(vb[i])) || bus.stat !== 2'b10 || bus.ready !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL b2b_done #%0d: data=%h stat=%b ready=%b, want data=%h stat=10 ready=1",
                 i, bus.data, bus.stat, bus.ready, 24'(int'(va[i]) + int'(vb[i])));
      end
    end
  endtask

  task automatic test_random;
    logic [15:0] ca;
    logic [15:0] cb;
    logic [23:0] ed;
    logic [1:0]  es;
    int          lat;
    for (int n = 0; n < 150; n++) begin
      ca = 16'($urandom);
      cb = 16'($urandom);
      if (ca[15:14] == 2'b11) ca[0] = ($urandom_range(0, 7) == 0);
      model(ca, cb, ed, es, lat);
      start_txn(ca, cb);
      for (int c = 0; c < lat; c++) begin
        if (c > 0) begin
          @(posedge clk);
          @(negedge clk);
        end
        vectors++;
        if (bus.stat !== 2'b01 || bus.ready !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL rand_busy #%0d cycle %0d: stat=%b ready=%b, want stat=01 ready=0",
                   n, c, bus.stat, bus.ready);
        end
      end
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if (bus.data !== ed || bus.stat !== es || bus.ready !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL rand_done #%0d ctrlA=%h ctrlB=%h: data=%h stat=%b ready=%b, want data=%h stat=%b ready=1",
                 n, ca, cb, bus.data, bus.stat, bus.ready, ed, es);
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (bus.data !== ed || bus.stat !== es) begin
          miscompares++;
          $display("[TB] FAIL rand_hold #%0d: data=%h stat=%b, want data=%h stat=%b",
                   n, bus.data, bus.stat, ed, es);
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    bus.req   = 1'b0;
    bus.ctrlA = '0;
    bus.ctrlB = '0;
    test_reset();
    test_directed();
    test_busy_ignore();
    test_mul_reset();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
